neuron_mac_lanes: RTL and testbench

Parametrised successor to the single-input neuron. It consumes LANES input/weight pairs per accepted beat and accumulates a NUM_INPUTS-long dot product in fixed point. It then adds a bias, rounds, applies a selectable activation and saturates. The result is presented on a valid/ready output. It sits between the layer input buffer and the next-layer buffer, and backpressures both directions.

---
 rtl/neuron_mac_lanes.sv | 115 +++++++++++
 tb/tb_neuron_mac_lanes.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_lanes.sv
// rtl/neuron_mac_lanes.sv - multi-lane fixed-point neuron: dot product, bias, round, activate, saturate
// Accepts LANES input/weight pairs per beat and emits one activated result per NUM_INPUTS-long vector.
module neuron_mac_lanes #(
  parameter int DATA_W     = 16,
  parameter int FRAC       = 15,
  parameter int LANES      = 4,
  parameter int NUM_INPUTS = 784,
  parameter int ACC_W      = 48,
  parameter int ACT_MODE   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*DATA_W-1:0]   in_data,
  input  logic [LANES*DATA_W-1:0]   in_weight,
  input  logic [DATA_W-1:0]         bias,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_sat
);

  localparam int BEATS      = (NUM_INPUTS + LANES - 1) / LANES;
  localparam int LAST_LANES = NUM_INPUTS - (BEATS - 1) * LANES;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic signed [ACC_W-1:0] MAX_R = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_R = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] HALF  = ACC_W'(1) << (FRAC - 1);

  typedef enum logic [1:0] {ACCUM, FINISH, OUT} state_t;

  state_t                        state, state_nx;
  logic [CNT_W-1:0]              beat_cnt;
  logic signed [ACC_W-1:0]       acc;
  logic signed [ACC_W-1:0]       beat_sum;
  logic signed [2*DATA_W-1:0]    d_ext [LANES];
  logic signed [2*DATA_W-1:0]    w_ext [LANES];
  logic signed [2*DATA_W-1:0]    prod  [LANES];
  logic signed [ACC_W-1:0]       bias_ext, s_val, r_val;
  logic [DATA_W-1:0]             res;
  logic                          res_sat;

  // Lanes past the end of the vector on the last beat contribute nothing.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      d_ext[i] = {{DATA_W{in_data[i*DATA_W+DATA_W-1]}}, in_data[i*DATA_W +: DATA_W]};
      w_ext[i] = {{DATA_W{in_weight[i*DATA_W+DATA_W-1]}}, in_weight[i*DATA_W +: DATA_W]};
      prod[i]  = d_ext[i] * w_ext[i];
      if (beat_cnt == LAST_BEAT && i >= LAST_LANES) prod[i] = '0;
      beat_sum = beat_sum + {{(ACC_W-2*DATA_W){prod[i][2*DATA_W-1]}}, prod[i]};
    end
  end

  always_comb begin
    bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
    s_val    = acc + (bias_ext <<< FRAC) + HALF;
    r_val    = s_val >>> FRAC;
    res      = r_val[DATA_W-1:0];
    res_sat  = 1'b0;
    if (ACT_MODE == 1 && r_val[ACC_W-1]) begin
      res = '0;
    end else if (r_val > MAX_R) begin
      res     = {1'b0, {(DATA_W-1){1'b1}}};
      res_sat = 1'b1;
    end else if (ACT_MODE == 0 && r_val < MIN_R) begin
      res     = {1'b1, {(DATA_W-1){1'b0}}};
      res_sat = 1'b1;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACCUM;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (in_valid && beat_cnt == LAST_BEAT) state_nx = FINISH;
      FINISH:  state_nx = OUT;
      OUT:     if (out_ready) state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      beat_cnt <= '0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (in_valid) begin
          acc      <= acc + beat_sum;
          beat_cnt <= beat_cnt + 1'b1;
        end
        FINISH: begin
          out_data <= res;
          out_sat  <= res_sat;
          acc      <= '0;
          beat_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_lanes.sv
// tb/tb_neuron_mac_lanes.sv - self-checking bench for neuron_mac_lanes (LANES=4, NUM_INPUTS=5)
// Two instances share stimulus: one in ReLU mode, one in linear mode.
module tb_neuron_mac_lanes;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int NI = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [LN*DW-1:0] in_data = '0;
  logic [LN*DW-1:0] in_weight = '0;
  logic [DW-1:0] bias = '0;
  logic rdy1, val1, sat1, rdy0, val0, sat0;
  logic [DW-1:0] od1, od0;

  always #5 clk = ~clk;

  neuron_mac_lanes #(.DATA_W(16), .FRAC(15), .LANES(LN), .NUM_INPUTS(NI), .ACC_W(48), .ACT_MODE(1)) u_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
    .in_weight(in_weight), .bias(bias), .out_valid(val1), .out_ready(out_ready),
    .out_data(od1), .out_sat(sat1));

  neuron_mac_lanes #(.DATA_W(16), .FRAC(15), .LANES(LN), .NUM_INPUTS(NI), .ACC_W(48), .ACT_MODE(0)) u_lin (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
    .in_weight(in_weight), .bias(bias), .out_valid(val0), .out_ready(out_ready),
    .out_data(od0), .out_sat(sat0));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] vd [NI];
  logic [DW-1:0] vw [NI];
  int  acc_cyc0, val_cyc;
  bit  timed_out;

  // Reference: real-valued dot product in integer LSB units, round half up, clamp.
  function automatic void model(input logic [DW-1:0] b, input int mode,
                                output logic [DW-1:0] d, output logic s);
    longint sum = 0;
    longint r;
    for (int i = 0; i < NI; i++)
      sum += longint'($signed(vd[i])) * longint'($signed(vw[i]));
    sum += longint'($signed(b)) * 32768 + 16384;
    r = sum >>> 15;
    s = 1'b0;
    if (mode == 1 && r < 0)  d = '0;
    else if (r > 32767)      begin d = 16'h7FFF; s = 1'b1; end
    else if (r < -32768)     begin d = 16'h8000; s = 1'b1; end
    else                     d = 16'(r);
  endfunction

  task automatic fill_vec(input logic [DW-1:0] d, input logic [DW-1:0] w);
    for (int i = 0; i < NI; i++) begin vd[i] = d; vw[i] = w; end
  endtask

  task automatic drive_beat(input int b, input bit junk_mask);
    bit acc = 0;
    for (int l = 0; l < LN; l++) begin
      if (b*LN + l < NI) begin
        in_data[l*DW +: DW]   = vd[b*LN + l];
        in_weight[l*DW +: DW] = vw[b*LN + l];
      end else begin
        in_data[l*DW +: DW]   = junk_mask ? 16'($urandom) : 16'h7FFF;
        in_weight[l*DW +: DW] = junk_mask ? 16'($urandom) : 16'h7FFF;
      end
    end
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (rdy1) begin
        @(posedge clk); #1;
        acc = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!acc) timed_out = 1;
    if (b == 0) acc_cyc0 = cyc;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    in_data   = {$urandom, $urandom};
    in_weight = {$urandom, $urandom};
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_vector(input int gap, input bit junk_mask);
    timed_out = 0;
    out_ready = 1'b0;
    drive_beat(0, junk_mask);
    idle(gap);
    drive_beat(1, junk_mask);
    begin
      bit seen = 0;
      for (int t = 0; t < 20; t++) begin
        if (val1) begin seen = 1; break; end
        @(posedge clk); #1;
      end
      if (!seen) timed_out = 1;
    end
    val_cyc = cyc;
  endtask

  task automatic handshake();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({rdy1, val1, od1, sat1} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_relu: rdy=%b val=%b data=%h sat=%b, want 1 0 0000 0", rdy1, val1, od1, sat1);
    end
    n_tests++;
    if ({rdy0, val0, od0, sat0} !== {1'b1, 1'b0, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_lin: rdy=%b val=%b data=%h sat=%b, want 1 0 0000 0", rdy0, val0, od0, sat0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    fill_vec(16'h2000, 16'h2000);
    bias = 16'h0800;
    send_vector(0, 0);
    n_tests++;
    if (timed_out || {od1, sat1} !== {16'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_result: data=%h sat=%b timeout=%0d, want 3000 0", od1, sat1, timed_out);
    end
    n_tests++;
    if (val_cyc - acc_cyc0 != 2) begin
      n_fail++;
      $display("FAIL basic_latency: %0d edges, want 2", val_cyc - acc_cyc0);
    end
    n_tests++;
    if (rdy1 !== 1'b0 || od0 !== 16'h3000) begin
      n_fail++;
      $display("FAIL basic_out_state: rdy=%b lin_data=%h, want 0 3000", rdy1, od0);
    end
    handshake();
  endtask

  task automatic test_relu_linear();
    fill_vec(16'h2000, 16'hE000);
    bias = 16'h0000;
    send_vector(0, 0);
    n_tests++;
    if (timed_out || {od1, sat1} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL relu_negative: data=%h sat=%b, want 0000 0", od1, sat1);
    end
    n_tests++;
    if ({od0, sat0} !== {16'hD800, 1'b0}) begin
      n_fail++;
      $display("FAIL linear_negative: data=%h sat=%b, want d800 0", od0, sat0);
    end
    handshake();
  endtask

  task automatic test_saturation();
    fill_vec(16'h7FFF, 16'h7FFF);
    bias = 16'h0000;
    send_vector(0, 0);
    n_tests++;
    if (timed_out || {od1, sat1, od0, sat0} !== {16'h7FFF, 1'b1, 16'h7FFF, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_positive: relu=%h/%b lin=%h/%b, want 7fff/1 both", od1, sat1, od0, sat0);
    end
    handshake();
    fill_vec(16'h8000, 16'h7FFF);
    send_vector(0, 0);
    n_tests++;
    if (timed_out || {od0, sat0} !== {16'h8000, 1'b1}) begin
      n_fail++;
      $display("FAIL sat_negative_lin: data=%h sat=%b, want 8000 1", od0, sat0);
    end
    n_tests++;
    if ({od1, sat1} !== {16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL sat_negative_relu: data=%h sat=%b, want 0000 0", od1, sat1);
    end
    handshake();
  endtask

  task automatic test_rounding();
    fill_vec(16'h0001, 16'h4000);
    bias = 16'h0000;
    send_vector(0, 0);
    n_tests++;
    if (timed_out || {od1, sat1, od0} !== {16'h0003, 1'b0, 16'h0003}) begin
      n_fail++;
      $display("FAIL rounding: relu=%h sat=%b lin=%h, want 0003 0 0003", od1, sat1, od0);
    end
    handshake();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e1, e0;
    logic s1, s0;
    bit bad = 0;
    fill_vec(16'h2000, 16'h2000);
    bias = 16'h0800;
    send_vector(2, 0);
    n_tests++;
    if (timed_out || {od1, sat1} !== {16'h3000, 1'b0}) begin
      n_fail++;
      $display("FAIL gap_result: data=%h sat=%b, want 3000 0", od1, sat1);
    end
    for (int t = 0; t < 10; t++) begin
      in_valid  = 1'b1;
      in_data   = {$urandom, $urandom};
      in_weight = {$urandom, $urandom};
      if (rdy1 !== 1'b0 || val1 !== 1'b1 || od1 !== 16'h3000) bad = 1;
      @(posedge clk); #1;
    end
    n_tests++;
    if (bad || rdy1 !== 1'b0 || od1 !== 16'h3000) begin
      n_fail++;
      $display("FAIL stall_hold: rdy=%b val=%b data=%h, want 0 1 3000 throughout", rdy1, val1, od1);
    end
    handshake();
    n_tests++;
    if (rdy1 !== 1'b1 || val1 !== 1'b0) begin
      n_fail++;
      $display("FAIL after_handshake: rdy=%b val=%b, want 1 0", rdy1, val1);
    end
    for (int i = 0; i < NI; i++) begin vd[i] = 16'($urandom_range(0, 8191)); vw[i] = 16'($urandom); end
    bias = 16'($urandom);
    model(bias, 1, e1, s1);
    model(bias, 0, e0, s0);
    send_vector(0, 1);
    n_tests++;
    if (timed_out || {od1, sat1, od0, sat0} !== {e1, s1, e0, s0}) begin
      n_fail++;
      $display("FAIL clean_next: relu=%h/%b lin=%h/%b, want %h/%b %h/%b", od1, sat1, od0, sat0, e1, s1, e0, s0);
    end
    handshake();
  endtask

  task automatic test_random();
    logic [DW-1:0] e1, e0;
    logic s1, s0;
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NI; i++) begin
        if (k % 2 == 0) begin vd[i] = 16'($urandom); vw[i] = 16'($urandom); end
        else begin
          vd[i] = 16'($urandom_range(0, 8191) - 4096);
          vw[i] = 16'($urandom_range(0, 8191) - 4096);
        end
      end
      bias = (k % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
      model(bias, 1, e1, s1);
      model(bias, 0, e0, s0);
      send_vector($urandom_range(0, 2), 1);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      n_tests++;
      if (timed_out || {od1, sat1, od0, sat0} !== {e1, s1, e0, s0}) begin
        n_fail++;
        $display("FAIL random_%0d: relu=%h/%b lin=%h/%b, want %h/%b %h/%b",
                 k, od1, sat1, od0, sat0, e1, s1, e0, s0);
      end
      handshake();
    end
  endtask

  task automatic test_reset_mid();
    fill_vec(16'h1234, 16'h4321);
    bias = 16'h0800;
    timed_out = 0;
    drive_beat(0, 0);
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({rdy1, val1, od1, sat1, rdy0, val0, od0, sat0} !==
        {1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: relu rdy=%b val=%b data=%h sat=%b lin data=%h, want 1 0 0000 0",
               rdy1, val1, od1, sat1, od0);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    fill_vec(16'h2000, 16'h2000);
    send_vector(0, 0);
    n_tests++;
    if (timed_out || {od1, sat1} !== {16'h3000, 1'b0} || val_cyc - acc_cyc0 != 2) begin
      n_fail++;
      $display("FAIL reset_mid_result: data=%h sat=%b latency=%0d, want 3000 0 2", od1, sat1, val_cyc - acc_cyc0);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu_linear();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
